// File: rtl/seq_pkg.sv
// Shared constants for the parametrised sequence detector.
// Holds the default pattern, counter width and fill-width helper.
package seq_pkg;

  localparam logic [3:0] DEF_PAT_1001 = 4'b1001;
  localparam int DEF_CW = 8;

  function automatic int fill_w(input int len);
    return $clog2(len + 1);
  endfunction

  localparam int DEF_FW = fill_w(4);

endpackage

// File: rtl/seq_detect_param_if.sv
// Serial-bit / pattern / match bundle for the sequence detector.
// master drives the stream and controls; slave is the detector.
interface seq_detect_param_if #(
  parameter int LEN = 4,
  parameter int CW  = 8
) ();

  logic           en;
  logic           i;
  logic           load;
  logic [LEN-1:0] pat_in;
  logic           overlap;
  logic           cnt_clr;
  logic           y;
  logic [CW-1:0]  match_cnt;
  logic [LEN-1:0] pat;

  modport master (
    output en, i, load, pat_in, overlap, cnt_clr,
    input  y, match_cnt, pat
  );

  modport slave (
    input  en, i, load, pat_in, overlap, cnt_clr,
    output y, match_cnt, pat
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear priority.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Moore sequence detector with a runtime-loadable LEN-bit pattern,
// registered match pulse and saturating match counter.
module seq_detect_param
  import seq_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] RST_PAT = LEN'(DEF_PAT_1001),
  parameter int             CW      = DEF_CW
) (
  input  logic                clk,
  input  logic                rst,
  seq_detect_param_if.slave   bus
);

  localparam int FW = fill_w(LEN);
  localparam logic [FW-1:0] FULL = FW'(LEN);

  logic [LEN-1:0] pat_q, pat_d;
  logic [LEN-1:0] hist_q, hist_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic           y_q, y_d;

  logic           accept;
  logic [LEN-1:0] hist_nx;
  logic [FW-1:0]  fill_nx;
  logic           match;

  assign accept  = bus.en && !bus.load;
  assign hist_nx = {hist_q[LEN-2:0], bus.i};
  assign fill_nx = (fill_q == FULL) ? FULL : fill_q + 1'b1;
  assign match   = accept && (hist_nx == pat_q) && (fill_nx == FULL);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    y_d    = match;
    if (bus.load) begin
      pat_d  = bus.pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = hist_nx;
      // Non-overlapping: consumed bits may not seed the next match
      fill_d = (match && !bus.overlap) ? '0 : fill_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= RST_PAT;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
    end
  end

  sat_counter #(
    .W (CW)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (match),
    .clr   (bus.cnt_clr),
    .cnt   (bus.match_cnt)
  );

  assign bus.y   = y_q;
  assign bus.pat = pat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: two instances (CW=8, CW=2)
// with hand-computed match pulses and counts.
module tb_seq_detect_param;

  logic clk;
  logic rst;

  int errs;
  int chks;

  seq_detect_param_if #(.LEN(4), .CW(8)) ba ();
  seq_detect_param_if #(.LEN(4), .CW(2)) bb ();

  seq_detect_param #(
    .LEN     (4),
    .RST_PAT (4'b1001),
    .CW      (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ba.slave)
  );

  seq_detect_param #(
    .LEN     (4),
    .RST_PAT (4'b1001),
    .CW      (2)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sa(input logic e, input logic b,
                    input logic ld = 1'b0,
                    input logic [3:0] p = 4'b0,
                    input logic clr = 1'b0);
    ba.en      = e;
    ba.i       = b;
    ba.load    = ld;
    ba.pat_in  = p;
    ba.cnt_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic sb(input logic e, input logic b,
                    input logic ld = 1'b0,
                    input logic [3:0] p = 4'b0,
                    input logic clr = 1'b0);
    bb.en      = e;
    bb.i       = b;
    bb.load    = ld;
    bb.pat_in  = p;
    bb.cnt_clr = clr;
    @(posedge clk);
    #1;
  endtask

  logic [6:0] s7;
  logic [6:0] y7;
  logic [6:0] e7;
  logic [6:0] b7;
  int         c;

  initial begin
    errs = 0;
    chks = 0;
    rst  = 1'b0;
    ba.en = 0; ba.i = 0; ba.load = 0; ba.pat_in = 0;
    ba.overlap = 1; ba.cnt_clr = 0;
    bb.en = 0; bb.i = 0; bb.load = 0; bb.pat_in = 0;
    bb.overlap = 1; bb.cnt_clr = 0;
    #12;
    chk("rst_y", ba.y, 0);
    chk("rst_cnt", ba.match_cnt, 0);
    chk("rst_pat", ba.pat, 4'b1001);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // T1: overlap, stream 1001001
    s7 = 7'b1001001;
    y7 = 7'b0001001;
    ba.overlap = 1;
    for (int k = 6; k >= 0; k--) begin
      sa(1'b1, s7[k]);
      chk($sformatf("t1_y%0d", 6 - k), ba.y, y7[k]);
    end
    chk("t1_cnt", ba.match_cnt, 2);

    // T2: non-overlap after clearing counter and history
    sa(1'b0, 1'b0, 1'b0, 4'b0, 1'b1);
    chk("t2_clr", ba.match_cnt, 0);
    sa(1'b0, 1'b0, 1'b1, 4'b1001);
    ba.overlap = 0;
    y7 = 7'b0001000;
    for (int k = 6; k >= 0; k--) begin
      sa(1'b1, s7[k]);
      chk($sformatf("t2_y%0d", 6 - k), ba.y, y7[k]);
    end
    chk("t2_cnt", ba.match_cnt, 1);

    // T3: load wins over a same-edge bit
    sa(1'b1, 1'b1, 1'b1, 4'b1101);
    chk("t3_pat", ba.pat, 4'b1101);
    chk("t3_y0", ba.y, 0);
    s7 = 7'b0001101;
    for (int k = 3; k >= 0; k--) begin
      sa(1'b1, s7[k]);
      chk($sformatf("t3_y%0d", 3 - k), ba.y, k == 0);
    end
    chk("t3_cnt", ba.match_cnt, 2);

    // T4: en gating, held bits carry a 1 that must be ignored
    sa(1'b0, 1'b0, 1'b1, 4'b1001);
    e7 = 7'b1010101;
    b7 = 7'b1101011;
    for (int k = 6; k >= 0; k--) begin
      sa(e7[k], b7[k]);
      chk($sformatf("t4_y%0d", 6 - k), ba.y, k == 0);
    end
    sa(1'b0, 1'b1);
    chk("t4_hold_y", ba.y, 0);
    chk("t4_cnt", ba.match_cnt, 3);

    // T5: CW=2, all-ones pattern, saturation and clear-vs-match
    bb.overlap = 1;
    sb(1'b0, 1'b0, 1'b1, 4'b1111);
    chk("t5_pat", bb.pat, 4'b1111);
    for (int n = 1; n <= 12; n++) begin
      sb(1'b1, 1'b1);
      c = (n < 4) ? 0 : ((n - 3 > 3) ? 3 : n - 3);
      chk($sformatf("t5_y%0d", n), bb.y, n >= 4);
      chk($sformatf("t5_c%0d", n), bb.match_cnt, c);
    end
    sb(1'b1, 1'b1, 1'b0, 4'b0, 1'b1);
    chk("t5_clr_y", bb.y, 1);
    chk("t5_clr_c", bb.match_cnt, 0);
    sb(1'b1, 1'b1);
    chk("t5_post_c", bb.match_cnt, 1);
    sb(1'b0, 1'b0);

    // T6: async reset mid-stream
    sa(1'b0, 1'b0, 1'b1, 4'b1101);
    chk("t6_pat0", ba.pat, 4'b1101);
    sa(1'b0, 1'b0, 1'b1, 4'b1001);
    sa(1'b1, 1'b1);
    sa(1'b1, 1'b0);
    sa(1'b1, 1'b0);
    sa(1'b0, 1'b0, 1'b1, 4'b1101);
    sa(1'b1, 1'b1);
    sa(1'b1, 1'b0);
    sa(1'b1, 1'b0);
    chk("t6_pre_cnt", ba.match_cnt, 3);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_y", ba.y, 0);
    chk("t6_cnt", ba.match_cnt, 0);
    chk("t6_pat", ba.pat, 4'b1001);
    chk("t6_cnt2", bb.match_cnt, 0);
    #1;
    rst = 1'b1;
    sa(1'b1, 1'b1);
    chk("t6_nomatch", ba.y, 0);
    chk("t6_post_cnt", ba.match_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
